exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception controller for the LEGv8 exception-capable CPU, directly downstream of the main decoder. Consumes the decoder's ERet strobe, an invalid-opcode flag from decode and an asynchronous external interrupt line. Decides when to divert fetch to the exception vector and when ERET returns. Holds the exception link register (ELR) and exception syndrome register (ESR).

## Interface
Parameters:
- PC_W, 64, PC/ELR width
- VECTOR, 64'h0000_0000_0000_00D8, exception handler entry address

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- instr_valid  in  1  current instruction is real (not a bubble); gates every decision
- pc  in  PC_W  address of current instruction
- eret  in  1  ERet from main decoder
- inv_op  in  1  current opcode not decodable
- ext_irq  in  1  external interrupt, asynchronous level
- redirect  out  1  override next PC this cycle
- redirect_pc  out  PC_W  next-PC value when redirect=1, else 0
- kill  out  1  suppress RegWrite/MemWrite of current instruction
- elr  out  PC_W  saved return address
- esr  out  4  syndrome: [0] invalid op, [1] external irq, [3] nested fault
- in_exc  out  1  handler active (state HANDLER)

## Operation
- States: RUN, HANDLER.
- ext_irq passes a 2-FF synchronizer. A synchronized rising edge sets sticky irq_pending. irq_pending clears only when the irq is taken. A level held high does not retrigger.
- RUN with instr_valid, priority inv_op > irq_pending:
  - redirect=1, redirect_pc=VECTOR, kill=1.
  - Next edge: elr<=pc, esr<=4'b0001 (inv_op) or 4'b0010 (irq), state<=HANDLER.
  - Irq take clears irq_pending.
- RUN with eret: ignored; no redirect, no state change.
- HANDLER, exceptions masked:
  - irq_pending is held, not taken.
  - inv_op with instr_valid: redirect to VECTOR, kill=1, esr[3]<=1 (sticky), elr unchanged, stay HANDLER.
  - eret with instr_valid: redirect=1, redirect_pc=elr, kill=0. Next edge: state<=RUN, esr<=0. elr keeps its value.
  - eret and inv_op together in HANDLER: inv_op wins.
- instr_valid=0: no redirect, no kill, no state or register change. Synchronizer and pending latch still run.

## Timing
- redirect, redirect_pc and kill are combinational from state, registers and current inputs. They are valid in the same cycle as the triggering instruction (single-cycle PC mux).
- elr, esr and in_exc are registered, updated on the edge ending the triggering cycle.
- ext_irq to irq_pending: 3 edges (2 sync + edge-detect register). The earliest take is the cycle after pending is set.
- Pending set while eret is retiring: eret completes. The irq is taken at the first valid instruction in RUN, at least 1 cycle after the return.
- Reset, including mid-handler: state=RUN, elr=0, esr=0, irq_pending=0, sync flops=0. The combinational outputs are then 0 (redirect=0, redirect_pc=0, kill=0, in_exc=0).

## Structure
- Package exc_pkg:
  - state enum {RUN, HANDLER}.
  - Cause bit constants ESR_INV=0, ESR_IRQ=1, ESR_NEST=3.
  - Default VECTOR constant.
- Sub-module irq_sync: 2-FF synchronizer plus rising-edge detect, with synchronous reset.
- Top: state register, ELR/ESR registers, pending latch, combinational redirect logic.

## Test plan
- Reset asserted 2 cycles, all inputs toggling -> all outputs 0; in_exc=0 after release.
- RUN, instr_valid=1, pc=0x40, inv_op=1 -> same cycle redirect=1, redirect_pc=0xD8, kill=1; next cycle elr=0x40, esr=0x1, in_exc=1.
- ext_irq raised at cycle 0, held high; valid instr pc=0x80 at cycle 4 -> redirect_pc=0xD8; then elr=0x80, esr=0x2; no second take after eret while the level stays high.
- HANDLER with elr=0x40; eret at pc=0xE0 -> redirect=1, redirect_pc=0x40, kill=0; next cycle in_exc=0, esr=0, elr=0x40.
- ext_irq edge arrives in HANDLER, eret retires while pending -> eret returns to elr. Next valid instr (pc=0x44) takes irq: elr=0x44, esr=0x2.
- inv_op in HANDLER after an irq take -> esr=0xA, elr unchanged, in_exc=1. Then reset mid-handler -> state RUN, elr=0, esr=0.

Source files
------------

// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared types and constants for the LEGv8 exception controller.
//   exc_state_e     : controller state (RUN = normal flow, HANDLER = in handler)
//   ESR_*           : bit positions inside the 4-bit exception syndrome register
//   DEFAULT_VECTOR  : default exception handler entry address
// ---------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } exc_state_e;

    // Syndrome bit positions
    localparam int ESR_INV  = 0;   // invalid opcode
    localparam int ESR_IRQ  = 1;   // external interrupt
    localparam int ESR_NEST = 3;   // fault raised while already in the handler

    localparam int ESR_W = 4;

    localparam logic [63:0] DEFAULT_VECTOR = 64'h0000_0000_0000_00D8;

    // Syndrome value for a fresh exception taken from RUN
    function automatic logic [ESR_W-1:0] cause_syndrome(input logic is_inv);
        logic [ESR_W-1:0] s;
        s = '0;
        if (is_inv) begin
            s[ESR_INV] = 1'b1;
        end else begin
            s[ESR_IRQ] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
// Brings the asynchronous external interrupt level into the clk domain with a
// two-flop synchronizer, then flags the synchronized rising edge.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset (clears all flops)
//   async_in  in   asynchronous interrupt level
//   rise      out  one-cycle pulse: synchronized level went 0 -> 1
// ---------------------------------------------------------------------------
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // A level held high produces exactly one pulse.
    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl
// Exception controller sitting after the main decoder. Diverts fetch to the
// handler vector on an invalid opcode or a pending external interrupt, and
// returns to the saved address on ERET. Holds ELR and ESR.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   instr_valid   current instruction is real; gates every decision
//   pc            address of the current instruction
//   eret          ERET strobe from the main decoder
//   inv_op        current opcode is not decodable
//   ext_irq       asynchronous external interrupt level
//   redirect      override next PC this cycle (combinational)
//   redirect_pc   next PC when redirect=1, else 0 (combinational)
//   kill          suppress register/memory writes of current instr (comb.)
//   elr           saved return address (registered)
//   esr           syndrome: [0] inv op, [1] irq, [3] nested fault (registered)
//   in_exc        handler active (registered state == HANDLER)
// ---------------------------------------------------------------------------
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int              PC_W   = 64,
    parameter logic [PC_W-1:0] VECTOR = PC_W'(DEFAULT_VECTOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [PC_W-1:0]  pc,
    input  logic             eret,
    input  logic             inv_op,
    input  logic             ext_irq,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             kill,
    output logic [PC_W-1:0]  elr,
    output logic [ESR_W-1:0] esr,
    output logic             in_exc
);

    exc_state_e       state_q, state_d;
    logic [PC_W-1:0]  elr_q, elr_d;
    logic [ESR_W-1:0] esr_q, esr_d;
    logic             pending_q, pending_d;

    logic irq_rise;

    irq_sync u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_irq),
        .rise     (irq_rise)
    );

    // -----------------------------------------------------------------------
    // Event decode. Reset masks the instruction so the combinational outputs
    // stay quiet while reset is held, whatever the inputs are doing.
    // -----------------------------------------------------------------------
    logic valid_eff;
    logic take_inv;     // invalid op in RUN
    logic take_irq;     // pending irq taken in RUN
    logic nest_fault;   // invalid op inside the handler (exceptions masked)
    logic do_return;    // ERET inside the handler

    assign valid_eff  = instr_valid & ~reset;
    assign take_inv   = valid_eff & (state_q == RUN) & inv_op;
    assign take_irq   = valid_eff & (state_q == RUN) & ~inv_op & pending_q;
    assign nest_fault = valid_eff & (state_q == HANDLER) & inv_op;
    assign do_return  = valid_eff & (state_q == HANDLER) & eret & ~inv_op;

    // -----------------------------------------------------------------------
    // State register (plus the architectural registers that move with it)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            elr_q     <= '0;
            esr_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            elr_q     <= elr_d;
            esr_q     <= esr_d;
            pending_q <= pending_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        esr_d   = esr_q;

        // A fresh edge sets pending even on the cycle an older one is taken,
        // so a genuine new request is never dropped.
        pending_d = (pending_q & ~take_irq) | irq_rise;

        unique case (state_q)
            RUN: begin
                if (take_inv || take_irq) begin
                    state_d = HANDLER;
                    elr_d   = pc;
                    esr_d   = cause_syndrome(take_inv);
                end
            end
            HANDLER: begin
                if (nest_fault) begin
                    esr_d[ESR_NEST] = 1'b1;
                end else if (do_return) begin
                    state_d = RUN;
                    esr_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: single-cycle PC mux override and write suppression
    // -----------------------------------------------------------------------
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        kill        = 1'b0;

        if (take_inv || take_irq || nest_fault) begin
            redirect    = 1'b1;
            redirect_pc = VECTOR;
            kill        = 1'b1;
        end else if (do_return) begin
            // The returning instruction itself must still retire.
            redirect    = 1'b1;
            redirect_pc = elr_q;
        end
    end

    assign elr    = elr_q;
    assign esr    = esr_q;
    assign in_exc = (state_q == HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl
// Directed vectors for exc_ctrl. The driver applies one input vector per cycle
// and pushes the hand-computed expected outputs into a queue; a monitor on the
// falling edge pops one expectation per cycle and compares every output.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [63:0] pc;
    logic        eret;
    logic        inv_op;
    logic        ext_irq;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        kill;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        in_exc;

    exc_ctrl #(
        .PC_W   (64),
        .VECTOR (64'h0000_0000_0000_00D8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .pc          (pc),
        .eret        (eret),
        .inv_op      (inv_op),
        .ext_irq     (ext_irq),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .kill        (kill),
        .elr         (elr),
        .esr         (esr),
        .in_exc      (in_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        red;
        logic [63:0] rpc;
        logic        kil;
        logic [63:0] elr;
        logic [3:0]  esr;
        logic        inx;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int vectors;
    int miscompares;

    localparam logic [63:0] VEC = 64'hD8;

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic rst, input logic v, input logic [63:0] p,
                        input logic er, input logic inv, input logic irq,
                        input logic e_red, input logic [63:0] e_rpc,
                        input logic e_kil, input logic [63:0] e_elr,
                        input logic [3:0] e_esr, input logic e_inx,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        instr_valid = v;
        pc          = p;
        eret        = er;
        inv_op      = inv;
        ext_irq     = irq;
        e.red = e_red;
        e.rpc = e_rpc;
        e.kil = e_kil;
        e.elr = e_elr;
        e.esr = e_esr;
        e.inx = e_inx;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (redirect !== e.red) begin
                miscompares++;
                $display("FAIL %s redirect: got %b want %b", nm, redirect, e.red);
            end
            if (redirect_pc !== e.rpc) begin
                miscompares++;
                $display("FAIL %s redirect_pc: got %h want %h", nm, redirect_pc, e.rpc);
            end
            if (kill !== e.kil) begin
                miscompares++;
                $display("FAIL %s kill: got %b want %b", nm, kill, e.kil);
            end
            if (elr !== e.elr) begin
                miscompares++;
                $display("FAIL %s elr: got %h want %h", nm, elr, e.elr);
            end
            if (esr !== e.esr) begin
                miscompares++;
                $display("FAIL %s esr: got %h want %h", nm, esr, e.esr);
            end
            if (in_exc !== e.inx) begin
                miscompares++;
                $display("FAIL %s in_exc: got %b want %b", nm, in_exc, e.inx);
            end
            $display("vec %0d %s: redirect=%b rpc=%h kill=%b elr=%h esr=%h in_exc=%b",
                     vectors, nm, redirect, redirect_pc, kill, elr, esr, in_exc);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        pc          = '0;
        eret        = 1'b0;
        inv_op      = 1'b0;
        ext_irq     = 1'b0;

        //      rst  v   pc        er  inv irq   red rpc     kil elr      esr   inx
        // Reset held two cycles with inputs toggling: everything quiet.
        step(1, 1, 64'h40,   1, 1, 1,   0, 0,      0, 64'h0,  4'h0, 0, "rst_a");
        step(1, 1, 64'h44,   1, 0, 0,   0, 0,      0, 64'h0,  4'h0, 0, "rst_b");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h0,  4'h0, 0, "rst_rel");

        // Invalid opcode in RUN.
        step(0, 1, 64'h40,   0, 1, 0,   1, VEC,    1, 64'h0,  4'h0, 0, "inv_take");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h40, 4'h1, 1, "inv_regs");
        // ERET from the handler.
        step(0, 1, 64'hE0,   1, 0, 0,   1, 64'h40, 0, 64'h40, 4'h1, 1, "eret_ret");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h40, 4'h0, 0, "eret_regs");
        // ERET in RUN is ignored.
        step(0, 1, 64'h50,   1, 0, 0,   0, 0,      0, 64'h40, 4'h0, 0, "eret_run");

        // External irq raised (cycle 0) and held high.
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h0, 0, "irq_c0");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h0, 0, "irq_c1");
        // Edge is only being detected now; pending is not set yet.
        step(0, 1, 64'h60,   0, 0, 1,   0, 0,      0, 64'h40, 4'h0, 0, "irq_early");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h0, 0, "irq_c3");
        step(0, 1, 64'h80,   0, 0, 1,   1, VEC,    1, 64'h40, 4'h0, 0, "irq_take");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h80, 4'h2, 1, "irq_regs");
        step(0, 1, 64'h100,  1, 0, 1,   1, 64'h80, 0, 64'h80, 4'h2, 1, "irq_eret");
        // Level still high: no retrigger.
        step(0, 1, 64'h84,   0, 0, 1,   0, 0,      0, 64'h80, 4'h0, 0, "irq_noretrig");
        step(0, 1, 64'h88,   0, 0, 0,   0, 0,      0, 64'h80, 4'h0, 0, "irq_drop");

        // Enter handler via invalid op, then an irq edge arrives while masked.
        step(0, 1, 64'h40,   0, 1, 0,   1, VEC,    1, 64'h80, 4'h0, 0, "h_inv");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h1, 1, "h_irq_up");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h1, 1, "h_wait1");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h40, 4'h1, 1, "h_wait2");
        // Pending now set, but masked in HANDLER.
        step(0, 1, 64'hD8,   0, 0, 1,   0, 0,      0, 64'h40, 4'h1, 1, "h_masked");
        step(0, 1, 64'hE0,   1, 0, 1,   1, 64'h40, 0, 64'h40, 4'h1, 1, "h_eret");
        // First valid instruction back in RUN takes the held irq.
        step(0, 1, 64'h44,   0, 0, 1,   1, VEC,    1, 64'h40, 4'h0, 0, "h_irq_take");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h44, 4'h2, 1, "h_irq_regs");

        // Nested invalid op: sticky esr[3], elr unchanged.
        step(0, 1, 64'h1000, 0, 1, 0,   1, VEC,    1, 64'h44, 4'h2, 1, "nest_inv");
        // ERET together with inv_op: inv_op wins.
        step(0, 1, 64'h2000, 1, 1, 0,   1, VEC,    1, 64'h44, 4'hA, 1, "nest_both");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h44, 4'hA, 1, "nest_regs");
        // Reset mid-handler (registers clear at the edge ending this cycle).
        step(1, 1, 64'h3000, 1, 1, 0,   0, 0,      0, 64'h44, 4'hA, 1, "mid_rst");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h0,  4'h0, 0, "mid_rst_rel");

        // Pending set, then reset: pending must be cleared.
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h0,  4'h0, 0, "pr_c0");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h0,  4'h0, 0, "pr_c1");
        step(0, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h0,  4'h0, 0, "pr_c2");
        step(1, 0, 64'h0,    0, 0, 1,   0, 0,      0, 64'h0,  4'h0, 0, "pr_rst");
        step(0, 1, 64'h300,  0, 0, 1,   0, 0,      0, 64'h0,  4'h0, 0, "pr_cleared");
        step(0, 0, 64'h0,    0, 0, 0,   0, 0,      0, 64'h0,  4'h0, 0, "pr_idle");

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
